// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: forwarding selects,
// controller states and operand-source slot indices.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_DEFAULT = 2'd0,
      FWD_MEM     = 2'd1,
      FWD_WB      = 2'd2
   } fwd_sel_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   localparam int NUM_SRC = 3;
   localparam int SRC_RS  = 0;
   localparam int SRC_RT  = 1;
   localparam int SRC_ST  = 2;

endpackage

// File: rtl/hazard_ctrl_fwd_compare.sv
// Per-operand comparator: picks the forwarding source for one ID operand
// against the EX and MEM shadow entries and flags a load-use hit.
module hazard_ctrl_fwd_compare
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              use_en,
   input  logic [REG_AW-1:0] addr,
   input  logic              ex_valid,
   input  logic              ex_wb_en,
   input  logic              ex_mem_r,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic              mem_valid,
   input  logic              mem_wb_en,
   input  logic [REG_AW-1:0] mem_dest,
   output logic [1:0]        sel,
   output logic              load_hit
);

   logic ex_match;
   logic mem_match;

   // Register 0 is hard-wired, so it never matches a producer.
   assign ex_match  = ex_valid  & ex_wb_en  & (ex_dest  == addr) & (addr != '0);
   assign mem_match = mem_valid & mem_wb_en & (mem_dest == addr) & (addr != '0);

   always_comb begin
      sel      = FWD_DEFAULT;
      load_hit = use_en & ex_match & ex_mem_r;
      if (use_en & ex_match & ~ex_mem_r) begin
         sel = FWD_MEM;
      end else if (use_en & mem_match) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline beside the ID/EX register.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
`ifdef HAZARD_STATS_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_is_store,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wb_en,
   input  logic              id_mem_r,
   output logic [1:0]        alu_1_sel,
   output logic [1:0]        alu_2_sel,
   output logic [1:0]        st_data_sel,
   output logic              stall_id,
   output logic              bubble_ex,
   output logic              ex_valid
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  fwd_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   state_e              state_reg, state_next;
   logic                ex_valid_reg, ex_wb_en_reg, ex_mem_r_reg;
   logic [REG_AW-1:0]   ex_dest_reg;
   logic                mem_valid_reg, mem_wb_en_reg;
   logic [REG_AW-1:0]   mem_dest_reg;
   logic [REG_AW-1:0]   src_addr [NUM_SRC];
   logic [NUM_SRC-1:0]  src_use;
   logic [NUM_SRC-1:0]  src_hit;
   logic [1:0]          src_sel  [NUM_SRC];
   logic [1:0]          sel_reg  [NUM_SRC];
   logic                load_use;
   logic                issue;

   assign src_addr[SRC_RS] = id_rs;
   assign src_addr[SRC_RT] = id_rt;
   assign src_addr[SRC_ST] = id_rt;
   assign src_use          = {id_is_store, id_uses_rt, id_uses_rs};

   // Producers older than MEM are already in the register file (write-before-read),
   // so only the EX and MEM shadow entries are compared.
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cmp
         hazard_ctrl_fwd_compare #(.REG_AW(REG_AW)) u_cmp (
            .use_en    (src_use[gi]),
            .addr      (src_addr[gi]),
            .ex_valid  (ex_valid_reg),
            .ex_wb_en  (ex_wb_en_reg),
            .ex_mem_r  (ex_mem_r_reg),
            .ex_dest   (ex_dest_reg),
            .mem_valid (mem_valid_reg),
            .mem_wb_en (mem_wb_en_reg),
            .mem_dest  (mem_dest_reg),
            .sel       (src_sel[gi]),
            .load_hit  (src_hit[gi])
         );
      end
   endgenerate

   assign load_use = id_valid & (|src_hit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (!mem_hold) begin
         if (flush) begin
            state_next = ST_RUN;
         end else if (load_use) begin
            state_next = ST_STALL;
         end else begin
            state_next = ST_RUN;
         end
      end
   end

   // Priority: mem_hold freezes everything, then flush, then load-use.
   always_comb begin
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      issue     = 1'b0;
      if (!mem_hold) begin
         if (flush) begin
            bubble_ex = 1'b1;
         end else if (load_use) begin
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end else begin
            issue = id_valid;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_reg  <= 1'b0;
         ex_wb_en_reg  <= 1'b0;
         ex_mem_r_reg  <= 1'b0;
         ex_dest_reg   <= '0;
         mem_valid_reg <= 1'b0;
         mem_wb_en_reg <= 1'b0;
         mem_dest_reg  <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            sel_reg[i] <= FWD_DEFAULT;
         end
      end else if (!mem_hold) begin
         mem_valid_reg <= ex_valid_reg;
         mem_wb_en_reg <= ex_wb_en_reg;
         mem_dest_reg  <= ex_dest_reg;
         ex_valid_reg  <= issue;
         ex_wb_en_reg  <= id_wb_en;
         ex_mem_r_reg  <= id_mem_r;
         ex_dest_reg   <= id_dest;
         for (int i = 0; i < NUM_SRC; i++) begin
            sel_reg[i] <= issue ? src_sel[i] : FWD_DEFAULT;
         end
      end
   end

   assign alu_1_sel   = sel_reg[SRC_RS];
   assign alu_2_sel   = sel_reg[SRC_RT];
   assign st_data_sel = sel_reg[SRC_ST];
   assign ex_valid    = ex_valid_reg;

`ifdef HAZARD_STATS_EN
   logic any_fwd;

   assign any_fwd = issue & ((|src_sel[SRC_RS]) | (|src_sel[SRC_RT]) | (|src_sel[SRC_ST]));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
         flush_cnt <= '0;
      end else if (!mem_hold) begin
         if (stall_id && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
         if (any_fwd && (fwd_cnt != {CNT_W{1'b1}}))    fwd_cnt   <= fwd_cnt + 1'b1;
         if (flush && (flush_cnt != {CNT_W{1'b1}}))    flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule
